tmds_encoder: RTL and testbench



---
 rtl/tmds_encoder.sv | 140 ++++++++++++++
 tb/tb_tmds_encoder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_encoder.sv
// Single-channel DVI TMDS 8b/10b encoder, three-stage pipeline with running disparity.
// Define TMDS_ENC_DISP_MON_EN to expose the running disparity on the `disparity` port.
module tmds_encoder (
    input  logic              pixel_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        din,
    input  logic              c0,
    input  logic              c1,
    input  logic              de,
    output logic [9:0]        dout
`ifdef TMDS_ENC_DISP_MON_EN
    ,
    output logic signed [4:0] disparity
`endif
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned SW = 6;

    localparam logic [9:0] CTRL_00 = 10'b1101010100;
    localparam logic [9:0] CTRL_01 = 10'b0010101011;
    localparam logic [9:0] CTRL_10 = 10'b0101010100;
    localparam logic [9:0] CTRL_11 = 10'b1010101011;

    // Stage 1 registers
    logic [DW-1:0] d1;
    logic [CW-1:0] n1d;
    logic          de1, c0_1, c1_1;

    // Stage 2 registers
    logic [8:0]    q_m;
    logic [CW-1:0] n1q, n0q;
    logic          de2, c0_2, c1_2;

    // Stage 3 registers
    logic signed [4:0] cnt;

    logic [CW-1:0]     n1d_c;
    logic [8:0]        q_m_c;
    logic [CW-1:0]     n1q_c;
    logic              xnor_c;
    logic [9:0]        dout_c;
    logic signed [4:0] cnt_c;

    logic signed [SW-1:0] cnt_ext_c, n1s_c, n0s_c, diff_c, two_q8_c, two_nq8_c, sum_c;

    // Ones count of the incoming pixel
    always_comb begin
        n1d_c = '0;
        for (int i = 0; i < int'(DW); i++) begin
            n1d_c = n1d_c + CW'(din[i]);
        end
    end

    // Transition-minimising stage: XOR or XNOR chain
    always_comb begin
        xnor_c   = (n1d > CW'(4)) || ((n1d == CW'(4)) && !d1[0]);
        q_m_c    = '0;
        q_m_c[0] = d1[0];
        for (int i = 1; i < int'(DW); i++) begin
            q_m_c[i] = xnor_c ? ~(q_m_c[i-1] ^ d1[i]) : (q_m_c[i-1] ^ d1[i]);
        end
        q_m_c[8] = ~xnor_c;
        n1q_c    = '0;
        for (int i = 0; i < int'(DW); i++) begin
            n1q_c = n1q_c + CW'(q_m_c[i]);
        end
    end

    // DC-balancing stage; sums kept 6 bits wide so intermediates cannot wrap
    always_comb begin
        n1s_c     = SW'(n1q);
        n0s_c     = SW'(n0q);
        diff_c    = n1s_c - n0s_c;
        cnt_ext_c = {cnt[4], cnt};
        two_q8_c  = {4'b0000, q_m[8], 1'b0};
        two_nq8_c = {4'b0000, ~q_m[8], 1'b0};
        sum_c     = '0;
        dout_c    = CTRL_00;
        cnt_c     = '0;
        if (!de2) begin
            unique case ({c1_2, c0_2})
                2'b00:   dout_c = CTRL_00;
                2'b01:   dout_c = CTRL_01;
                2'b10:   dout_c = CTRL_10;
                default: dout_c = CTRL_11;
            endcase
        end else if ((cnt == 5'sd0) || (n1q == n0q)) begin
            dout_c = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            sum_c  = q_m[8] ? (cnt_ext_c + diff_c) : (cnt_ext_c - diff_c);
            cnt_c  = 5'(sum_c);
        end else if ((!cnt[4] && (n1q > n0q)) || (cnt[4] && (n0q > n1q))) begin
            dout_c = {1'b1, q_m[8], ~q_m[7:0]};
            sum_c  = cnt_ext_c + two_q8_c - diff_c;
            cnt_c  = 5'(sum_c);
        end else begin
            dout_c = {1'b0, q_m[8], q_m[7:0]};
            sum_c  = cnt_ext_c + diff_c - two_nq8_c;
            cnt_c  = 5'(sum_c);
        end
    end

    always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            d1   <= '0;
            n1d  <= '0;
            de1  <= 1'b0;
            c0_1 <= 1'b0;
            c1_1 <= 1'b0;
            q_m  <= '0;
            n1q  <= '0;
            n0q  <= '0;
            de2  <= 1'b0;
            c0_2 <= 1'b0;
            c1_2 <= 1'b0;
            dout <= '0;
            cnt  <= '0;
        end else begin
            d1   <= din;
            n1d  <= n1d_c;
            de1  <= de;
            c0_1 <= c0;
            c1_1 <= c1;
            q_m  <= q_m_c;
            n1q  <= n1q_c;
            n0q  <= CW'(DW) - n1q_c;
            de2  <= de1;
            c0_2 <= c0_1;
            c1_2 <= c1_1;
            dout <= dout_c;
            cnt  <= cnt_c;
        end
    end

`ifdef TMDS_ENC_DISP_MON_EN
    assign disparity = cnt;
`endif

endmodule

// File: tb/tb_tmds_encoder.sv
// Scoreboard bench for tmds_encoder: reference model pushes expected symbols, a monitor pops and compares.
module tb_tmds_encoder;

    logic              pixel_clk = 1'b0;
    logic              sys_rst_n = 1'b0;
    logic [7:0]        din = '0;
    logic              c0 = 1'b0;
    logic              c1 = 1'b0;
    logic              de = 1'b0;
    logic [9:0]        dout;
    logic signed [4:0] disparity;

    tmds_encoder dut (
        .pixel_clk (pixel_clk),
        .sys_rst_n (sys_rst_n),
        .din       (din),
        .c0        (c0),
        .c1        (c1),
        .de        (de),
        .dout      (dout)
`ifdef TMDS_ENC_DISP_MON_EN
        ,
        .disparity (disparity)
`endif
    );

`ifndef TMDS_ENC_DISP_MON_EN
    assign disparity = '0;
`endif

    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic [9:0]        sym;
        logic signed [4:0] disp;
        int                due;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   m_cnt = 0;
    int   n_vec = 0;
    int   n_err = 0;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    // Reference encoder written from the symbol rules with integer arithmetic
    function automatic logic [9:0] model(input logic v, input logic [7:0] d, input logic [1:0] c);
        int         n1d, ones, diff;
        logic       xn, q8;
        logic [7:0] qm, msk;
        logic [9:0] sym;
        if (!v) begin
            m_cnt = 0;
            case (c)
                2'b00:   sym = 10'b1101010100;
                2'b01:   sym = 10'b0010101011;
                2'b10:   sym = 10'b0101010100;
                default: sym = 10'b1010101011;
            endcase
            return sym;
        end
        n1d = $countones(d);
        xn  = (n1d > 4) || (n1d == 4 && d[0] == 1'b0);
        // XOR chain = prefix parity; XNOR chain flips every odd bit of it
        for (int i = 0; i < 8; i++) begin
            msk   = 8'((1 << (i + 1)) - 1);
            qm[i] = ($countones(d & msk) % 2 == 1) ^ (xn && (i % 2 == 1));
        end
        q8   = !xn;
        ones = $countones(qm);
        diff = ones - (8 - ones);
        if (m_cnt == 0 || diff == 0) begin
            sym   = {~q8, q8, q8 ? qm : ~qm};
            m_cnt = m_cnt + (q8 ? diff : -diff);
        end else if ((m_cnt > 0 && diff > 0) || (m_cnt < 0 && diff < 0)) begin
            sym   = {1'b1, q8, ~qm};
            m_cnt = m_cnt + 2 * int'(q8) - diff;
        end else begin
            sym   = {1'b0, q8, qm};
            m_cnt = m_cnt + diff - 2 * (1 - int'(q8));
        end
        return sym;
    endfunction

    task automatic push(input logic [9:0] s, input int dsp, input int due);
        exp_t e;
        e.sym  = s;
        e.disp = 5'(dsp);
        e.due  = due;
        sb.push_back(e);
    endtask

    // Apply one input now (cyc already settled); use_k swaps in literal expectations
    task automatic apply(input logic v, input logic [7:0] d, input logic [1:0] c,
                         input bit use_k = 1'b0, input logic [9:0] k_sym = '0, input int k_disp = 0);
        logic [9:0] s;
        de  = v;
        din = d;
        {c1, c0} = c;
        s = model(v, d, c);
        if (use_k) push(k_sym, k_disp, cyc + 3);
        else       push(s, m_cnt, cyc + 3);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] c,
                         input bit use_k = 1'b0, input logic [9:0] k_sym = '0, input int k_disp = 0);
        @(posedge pixel_clk);
        #1;
        apply(v, d, c, use_k, k_sym, k_disp);
    endtask

    task automatic chk(input string nm, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %b, want %b", nm, cyc, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_dout"}, dout, 10'h000);
`ifdef TMDS_ENC_DISP_MON_EN
        chk({nm, "_disp"}, 10'(disparity), 10'(0));
`endif
    endtask

    // Release reset; the two reset-state pipeline slots emit the 00 control token
    task automatic release_and_apply(input logic v, input logic [7:0] d, input logic [1:0] c,
                                     input bit use_k = 1'b0, input logic [9:0] k_sym = '0,
                                     input int k_disp = 0);
        @(posedge pixel_clk);
        #1;
        sys_rst_n = 1'b1;
        m_cnt = 0;
        push(10'b1101010100, 0, cyc + 1);
        push(10'b1101010100, 0, cyc + 2);
        apply(v, d, c, use_k, k_sym, k_disp);
    endtask

    // Monitor: compare every symbol whose due cycle has arrived
    always @(negedge pixel_clk) begin
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            chk("dout", dout, sb[0].sym);
`ifdef TMDS_ENC_DISP_MON_EN
            chk("disparity", 10'(disparity), 10'(sb[0].disp));
            n_vec++;
            if (disparity > 5'sd8 || disparity < -5'sd8) begin
                n_err++;
                $display("FAIL disp_range @cyc %0d: got %0d, want within -8..8", cyc, disparity);
            end
`endif
            void'(sb.pop_front());
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish, want finish before 2ms");
        $fatal(1, "timeout");
    end

    initial begin
        int wait_cyc;
        logic v;

        // Reset held for 5 clocks
        repeat (5) @(posedge pixel_clk);
        #1;
        chk_reset_outputs("por");
        release_and_apply(1'b0, 8'h00, 2'b00);
        repeat (3) drive(1'b0, 8'h00, 2'b00);

        // Control tokens
        drive(1'b0, 8'h5A, 2'b00, 1'b1, 10'b1101010100, 0);
        drive(1'b0, 8'h5A, 2'b01, 1'b1, 10'b0010101011, 0);
        drive(1'b0, 8'h5A, 2'b10, 1'b1, 10'b0101010100, 0);
        drive(1'b0, 8'h5A, 2'b11, 1'b1, 10'b1010101011, 0);
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100, 0);

        // Repeated zeros from cnt=0
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'b0100000000, -8);
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'b1111111111, 2);
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'b0100000000, -6);
        drive(1'b1, 8'h00, 2'b00, 1'b1, 10'b1111111111, 4);
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100, 0);

        // Single full pixel then control
        drive(1'b1, 8'hFF, 2'b00, 1'b1, 10'b1000000000, -8);
        drive(1'b0, 8'h00, 2'b00, 1'b1, 10'b1101010100, 0);

        // Reset in the middle of a video period
        repeat (6) drive(1'b1, 8'($urandom), 2'b00);
        @(posedge pixel_clk);
        #1;
        sys_rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        sb.delete();
        m_cnt = 0;
        repeat (3) @(posedge pixel_clk);
        #1;
        chk_reset_outputs("mid_rst_hold");
        release_and_apply(1'b1, 8'h00, 2'b00, 1'b1, 10'b0100000000, -8);
        drive(1'b0, 8'h00, 2'b00);

        // Random soak with random de gaps
        for (int i = 0; i < 10000; i++) begin
            v = ($urandom_range(0, 7) != 0);
            drive(v, 8'($urandom), 2'($urandom));
        end
        repeat (4) drive(1'b0, 8'h00, 2'b00);

        wait_cyc = 0;
        while (sb.size() > 0 && wait_cyc < 10) begin
            @(posedge pixel_clk);
            wait_cyc++;
        end
        @(negedge pixel_clk);
        n_vec++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending symbols, want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
